shazam_frame_scheduler: RTL and testbench

Sequences one analysis frame at a time through the shazam datapath.
- Gates ADC samples into the analysis core for exactly FRAME_LEN samples.
- Waits for the core's peak-found strobe.
- Loads the PISO only when the 9-bit dual-clock FIFO has room for a full set of maxima, then waits for serialisation to finish before opening the next frame.
- Sits between the top-level start/ADC inputs and shazam_core/PISO/DUAL_CLK_FIFO, all in the 50 MHz write-clock domain.

---
 rtl/shazam_frame_scheduler_if.sv | 62 ++++++
 rtl/shazam_frame_scheduler.sv | 177 +++++++++++++++++
 tb/tb_shazam_frame_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shazam_frame_scheduler_if.sv
// Signal bundle between shazam_frame_scheduler and the surrounding shazam datapath.
// master = scheduler side, slave = start/ADC/core/PISO/FIFO side.
// timeout_flag exists only when SHAZAM_FRAME_TIMEOUT_EN is defined.
interface shazam_frame_scheduler_if #(
  parameter int unsigned FIFO_AW = 16
);
  localparam int unsigned FREE_W = FIFO_AW + 1;

  logic              start;
  logic              adc_data_valid;
  logic              sample_valid_out;
  logic              core_run;
  logic              peaks_ready;
  logic [FREE_W-1:0] fifo_free;
  logic              piso_load;
  logic              piso_active;
  logic [15:0]       frame_count;
  logic              frame_done;
  logic              frame_abort;
  logic [2:0]        state_dbg;
`ifdef SHAZAM_FRAME_TIMEOUT_EN
  logic              timeout_flag;
`endif

  modport master (
    input  start,
    input  adc_data_valid,
    input  peaks_ready,
    input  fifo_free,
    input  piso_active,
    output sample_valid_out,
    output core_run,
    output piso_load,
    output frame_count,
    output frame_done,
    output frame_abort,
    output state_dbg
`ifdef SHAZAM_FRAME_TIMEOUT_EN
    ,
    output timeout_flag
`endif
  );

  modport slave (
    output start,
    output adc_data_valid,
    output peaks_ready,
    output fifo_free,
    output piso_active,
    input  sample_valid_out,
    input  core_run,
    input  piso_load,
    input  frame_count,
    input  frame_done,
    input  frame_abort,
    input  state_dbg
`ifdef SHAZAM_FRAME_TIMEOUT_EN
    ,
    input  timeout_flag
`endif
  );
endinterface

// File: rtl/shazam_frame_scheduler.sv
// Frame scheduler for the shazam datapath (50 MHz write-clock domain).
// Gates FRAME_LEN ADC samples into the core, waits for peaks, loads the PISO
// once the FIFO can take a full set of maxima, then waits for the PISO to drain.
// Optional WAIT_PEAKS watchdog: define SHAZAM_FRAME_TIMEOUT_EN.
module shazam_frame_scheduler #(
  parameter int unsigned FRAME_LEN      = 512,
  parameter int unsigned MAXIMAS_COUNT  = 11,
  parameter int unsigned FIFO_AW        = 16
`ifdef SHAZAM_FRAME_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
  input logic                      clk,
  input logic                      rst_n,
  shazam_frame_scheduler_if.master bus
);

  localparam int unsigned FREE_W = FIFO_AW + 1;
  localparam int unsigned CNT_W  = $clog2(FRAME_LEN);
  localparam logic [FREE_W-1:0] ROOM_NEED   = FREE_W'(MAXIMAS_COUNT);
  localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'(FRAME_LEN - 1);
`ifdef SHAZAM_FRAME_TIMEOUT_EN
  localparam int unsigned TO_W = 20;
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CAPTURE    = 3'd1,
    WAIT_PEAKS = 3'd2,
    WAIT_ROOM  = 3'd3,
    LOAD       = 3'd4,
    DRAIN      = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] sample_cnt;
  logic             drain_armed;
  logic [15:0]      frame_count_q;
  logic             core_run_q;
  logic             piso_load_q;
  logic             frame_done_q;
  logic             frame_abort_q;
  logic             room_ok_c;
  logic             last_sample_c;
`ifdef SHAZAM_FRAME_TIMEOUT_EN
  logic [TO_W-1:0]  wait_cnt;
  logic             timeout_q;
`endif

  // Full-width unsigned room test and final-sample detect.
  assign room_ok_c     = (bus.fifo_free >= ROOM_NEED);
  assign last_sample_c = bus.adc_data_valid && (sample_cnt == LAST_SAMPLE);

  // Frame sequencer: state, sample counter, frame counter and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      sample_cnt    <= '0;
      drain_armed   <= 1'b0;
      frame_count_q <= '0;
      core_run_q    <= 1'b0;
      piso_load_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
`ifdef SHAZAM_FRAME_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      piso_load_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= CAPTURE;
            sample_cnt <= '0;
            core_run_q <= 1'b1;
`ifdef SHAZAM_FRAME_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
          end
        end
        CAPTURE: begin
          if (!bus.start) begin
            state         <= IDLE;
            core_run_q    <= 1'b0;
            frame_abort_q <= 1'b1;
          end else if (bus.adc_data_valid) begin
            if (last_sample_c) begin
              state      <= WAIT_PEAKS;
              sample_cnt <= '0;
`ifdef SHAZAM_FRAME_TIMEOUT_EN
              wait_cnt   <= '0;
`endif
            end else begin
              sample_cnt <= sample_cnt + CNT_W'(1);
            end
          end
        end
        WAIT_PEAKS: begin
          if (!bus.start) begin
            state         <= IDLE;
            core_run_q    <= 1'b0;
            frame_abort_q <= 1'b1;
          end else if (bus.peaks_ready) begin
            if (room_ok_c) begin
              state       <= LOAD;
              piso_load_q <= 1'b1;
            end else begin
              state <= WAIT_ROOM;
            end
          end
`ifdef SHAZAM_FRAME_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            state         <= IDLE;
            core_run_q    <= 1'b0;
            frame_abort_q <= 1'b1;
            timeout_q     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
`endif
        end
        WAIT_ROOM: begin
          if (!bus.start) begin
            state         <= IDLE;
            core_run_q    <= 1'b0;
            frame_abort_q <= 1'b1;
          end else if (room_ok_c) begin
            state       <= LOAD;
            piso_load_q <= 1'b1;
          end
        end
        LOAD: begin
          state       <= DRAIN;
          drain_armed <= 1'b0;
        end
        DRAIN: begin
          // First DRAIN cycle gives the PISO time to raise output_active.
          if (!drain_armed) begin
            drain_armed <= 1'b1;
          end else if (!bus.piso_active) begin
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
            if (bus.start) begin
              state      <= CAPTURE;
              sample_cnt <= '0;
            end else begin
              state      <= IDLE;
              core_run_q <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          core_run_q <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping; sample gate is the only combinational path.
  assign bus.sample_valid_out = bus.adc_data_valid && (state == CAPTURE);
  assign bus.core_run         = core_run_q;
  assign bus.piso_load        = piso_load_q;
  assign bus.frame_count      = frame_count_q;
  assign bus.frame_done       = frame_done_q;
  assign bus.frame_abort      = frame_abort_q;
  assign bus.state_dbg        = state;
`ifdef SHAZAM_FRAME_TIMEOUT_EN
  assign bus.timeout_flag     = timeout_q;
`endif

endmodule

// File: tb/tb_shazam_frame_scheduler.sv
// Scoreboard bench for shazam_frame_scheduler; exercises the timeout path
// when SHAZAM_FRAME_TIMEOUT_EN is defined.
module tb_shazam_frame_scheduler;

  localparam int unsigned FRAME_LEN     = 8;
  localparam int unsigned MAXIMAS_COUNT = 11;
  localparam int unsigned FIFO_AW       = 16;
`ifdef SHAZAM_FRAME_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYCLES = 50;
`endif
  localparam int PISO_BUSY = 11;
  localparam int EV_LOAD   = 0;
  localparam int EV_DONE   = 1;
  localparam int EV_ABORT  = 2;
  localparam int S_IDLE = 0, S_CAPTURE = 1, S_WAIT_PEAKS = 2, S_WAIT_ROOM = 3,
                 S_LOAD = 4, S_DRAIN = 5;

  typedef struct {
    int kind;
    int samples;
    int fcount;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   sv_cnt   = 0;
  ev_t  exp_q[$];

  shazam_frame_scheduler_if #(.FIFO_AW(FIFO_AW)) bus ();

  shazam_frame_scheduler #(
    .FRAME_LEN(FRAME_LEN),
    .MAXIMAS_COUNT(MAXIMAS_COUNT),
    .FIFO_AW(FIFO_AW)
`ifdef SHAZAM_FRAME_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void expect_ev(input int kind, input int samples, input int fcount);
    ev_t ev;
    ev.kind    = kind;
    ev.samples = samples;
    ev.fcount  = fcount;
    exp_q.push_back(ev);
  endfunction

  // Pop the oldest expected event and compare it with what the DUT presented.
  task automatic take(input int kind);
    ev_t ev;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
    end else begin
      ev = exp_q.pop_front();
      chk("event_kind", 32'(kind), 32'(ev.kind));
      if (ev.samples >= 0) chk("event_samples", 32'(sv_cnt), 32'(ev.samples));
      chk("event_frame_count", 32'(bus.frame_count), 32'(ev.fcount));
    end
    if (kind != EV_DONE) sv_cnt = 0;
  endtask

  // Monitor: counts gated samples and scores load/done/abort strobes.
  always @(negedge clk) begin
    if (!rst_n) begin
      sv_cnt = 0;
    end else begin
      if (bus.sample_valid_out === 1'b1) sv_cnt++;
      if (bus.piso_load === 1'b1)   take(EV_LOAD);
      if (bus.frame_done === 1'b1)  take(EV_DONE);
      if (bus.frame_abort === 1'b1) take(EV_ABORT);
    end
  end

  // PISO stand-in: output_active for PISO_BUSY cycles starting the cycle after load.
  initial begin
    int   left;
    logic prev_load;
    left = 0;
    prev_load = 1'b0;
    bus.piso_active = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (left > 0) left--;
      if (prev_load) left = PISO_BUSY;
      if (!rst_n) left = 0;
      bus.piso_active = (left > 0);
      prev_load = bus.piso_load;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not reach its end, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n ADC strobes, one every third cycle; returns the cycle after the last strobe's edge.
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      step();
      bus.adc_data_valid = 1'b1;
      step();
      bus.adc_data_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk(name, 32'(bus.frame_done), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"},        32'(bus.state_dbg),        32'(S_IDLE));
    chk({tag, "_core_run"},     32'(bus.core_run),         32'd0);
    chk({tag, "_piso_load"},    32'(bus.piso_load),        32'd0);
    chk({tag, "_frame_done"},   32'(bus.frame_done),       32'd0);
    chk({tag, "_frame_abort"},  32'(bus.frame_abort),      32'd0);
    chk({tag, "_frame_count"},  32'(bus.frame_count),      32'd0);
    chk({tag, "_sample_valid"}, 32'(bus.sample_valid_out), 32'd0);
  endtask

  initial begin
    int n_room;
    int early;
`ifdef SHAZAM_FRAME_TIMEOUT_EN
    int n_wp;
    int n;
`endif
    rst_n              = 1'b0;
    bus.start          = 1'b0;
    bus.adc_data_valid = 1'b1;
    bus.peaks_ready    = 1'b0;
    bus.fifo_free      = (FIFO_AW + 1)'(100);
    step();
    step();
    check_idle("reset");
    bus.adc_data_valid = 1'b0;
    rst_n = 1'b1;

    // Basic frame, samples during WAIT_PEAKS must be dropped.
    expect_ev(EV_LOAD, 8, 0);
    expect_ev(EV_DONE, -1, 1);
    bus.start = 1'b1;
    step();
    chk("t1_enter_capture", 32'(bus.state_dbg), 32'(S_CAPTURE));
    chk("t1_core_run", 32'(bus.core_run), 32'd1);
    feed(FRAME_LEN);
    chk("t1_wait_peaks", 32'(bus.state_dbg), 32'(S_WAIT_PEAKS));
    bus.adc_data_valid = 1'b1;
    repeat (4) step();
    bus.adc_data_valid = 1'b0;
    bus.peaks_ready = 1'b1;
    step();
    bus.peaks_ready = 1'b0;
    chk("t1_load_state", 32'(bus.state_dbg), 32'(S_LOAD));
    wait_done("t1_done");
    chk("t1_back_to_back", 32'(bus.state_dbg), 32'(S_CAPTURE));
    chk("t1_frame_count", 32'(bus.frame_count), 32'd1);

    // FIFO backpressure: 10 free words holds WAIT_ROOM, 11 releases it.
    expect_ev(EV_LOAD, 8, 1);
    expect_ev(EV_DONE, -1, 2);
    feed(FRAME_LEN);
    bus.fifo_free = (FIFO_AW + 1)'(10);
    step();
    bus.peaks_ready = 1'b1;
    step();
    bus.peaks_ready = 1'b0;
    n_room = 0;
    early  = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.state_dbg === 3'(S_WAIT_ROOM)) n_room++;
      if (bus.piso_load === 1'b1) early++;
      step();
    end
    chk("t2_wait_room_cycles", 32'(n_room), 32'd40);
    chk("t2_no_early_load", 32'(early), 32'd0);
    bus.fifo_free = (FIFO_AW + 1)'(11);
    step();
    chk("t2_load_after_room", 32'(bus.piso_load), 32'd1);
    bus.fifo_free = (FIFO_AW + 1)'(100);
    wait_done("t2_done");
    chk("t2_frame_count", 32'(bus.frame_count), 32'd2);

    // Abort after 5 of 8 samples.
    expect_ev(EV_ABORT, 5, 2);
    feed(5);
    bus.start = 1'b0;
    step();
    chk("t3_idle", 32'(bus.state_dbg), 32'(S_IDLE));
    chk("t3_abort_pulse", 32'(bus.frame_abort), 32'd1);
    chk("t3_core_run_low", 32'(bus.core_run), 32'd0);
    step();
    chk("t3_abort_one_cycle", 32'(bus.frame_abort), 32'd0);
    chk("t3_count_kept", 32'(bus.frame_count), 32'd2);

    // Restart needs 8 fresh samples; stop while draining completes the frame.
    expect_ev(EV_LOAD, 8, 2);
    expect_ev(EV_DONE, -1, 3);
    bus.start = 1'b1;
    step();
    chk("t3_restart", 32'(bus.state_dbg), 32'(S_CAPTURE));
    feed(FRAME_LEN);
    bus.peaks_ready = 1'b1;
    step();
    bus.peaks_ready = 1'b0;
    step();
    chk("t4_drain", 32'(bus.state_dbg), 32'(S_DRAIN));
    bus.start = 1'b0;
    wait_done("t4_done");
    chk("t4_idle", 32'(bus.state_dbg), 32'(S_IDLE));
    chk("t4_frame_count", 32'(bus.frame_count), 32'd3);
    step();
    chk("t4_stays_idle", 32'(bus.state_dbg), 32'(S_IDLE));

    // Reset while in WAIT_ROOM.
    bus.start = 1'b1;
    step();
    feed(FRAME_LEN);
    bus.fifo_free = (FIFO_AW + 1)'(10);
    bus.peaks_ready = 1'b1;
    step();
    bus.peaks_ready = 1'b0;
    chk("t5_wait_room", 32'(bus.state_dbg), 32'(S_WAIT_ROOM));
    rst_n = 1'b0;
    step();
    check_idle("t5_reset");
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.fifo_free = (FIFO_AW + 1)'(100);
    step();
    chk("t5_no_abort", 32'(bus.frame_abort), 32'd0);

    // Frame counter wrap from 0xFFFF.
    force dut.frame_count_q = 16'hFFFF;
    step();
    release dut.frame_count_q;
    step();
    chk("t6_preload", 32'(bus.frame_count), 32'd65535);
    expect_ev(EV_LOAD, 8, 65535);
    expect_ev(EV_DONE, -1, 0);
    bus.start = 1'b1;
    step();
    feed(FRAME_LEN);
    bus.peaks_ready = 1'b1;
    step();
    bus.peaks_ready = 1'b0;
    wait_done("t6_done");
    chk("t6_wrap", 32'(bus.frame_count), 32'd0);

`ifdef SHAZAM_FRAME_TIMEOUT_EN
    // Watchdog: peaks withheld, abort after TIMEOUT_CYCLES in WAIT_PEAKS.
    expect_ev(EV_ABORT, 8, 0);
    feed(FRAME_LEN);
    n_wp = 0;
    n    = 0;
    while (bus.frame_abort !== 1'b1 && n < 200) begin
      if (bus.state_dbg === 3'(S_WAIT_PEAKS)) n_wp++;
      step();
      n++;
    end
    chk("t6_timeout_abort", 32'(bus.frame_abort), 32'd1);
    chk("t6_timeout_cycles", 32'(n_wp), 32'(TIMEOUT_CYCLES));
    chk("t6_timeout_flag", 32'(bus.timeout_flag), 32'd1);
    bus.start = 1'b0;
    step();
    step();
    chk("t6_flag_sticky", 32'(bus.timeout_flag), 32'd1);
    bus.start = 1'b1;
    step();
    chk("t6_flag_cleared", 32'(bus.timeout_flag), 32'd0);
    chk("t6_recapture", 32'(bus.state_dbg), 32'(S_CAPTURE));
`endif

    // Leave via an abort with no samples taken.
    expect_ev(EV_ABORT, 0, 0);
    bus.start = 1'b0;
    step();
    chk("end_idle", 32'(bus.state_dbg), 32'(S_IDLE));
    step();
    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
